// File: rtl/pose_accumulate_pkg.sv
// pose_accumulate_pkg: pose widths, identity pose, entry indices, compose latency and sequencer states
package pose_accumulate_pkg;
  localparam int POSE_BW_DEF = 64;
  localparam int FRAC_BW_DEF = 24;
  localparam int POSE_COMPOSE_LAT = 40;
  localparam int R00 = 0, R01 = 1, R02 = 2, T0 = 3;
  localparam int R10 = 4, R11 = 5, R12 = 6, T1 = 7;
  localparam int R20 = 8, R21 = 9, R22 = 10, T2 = 11;
  localparam logic [POSE_BW_DEF-1:0] POSE_ONE = POSE_BW_DEF'(1) << FRAC_BW_DEF;
  localparam logic [POSE_BW_DEF-1:0] POSE_ZERO = POSE_BW_DEF'(0);
  localparam logic [11:0][POSE_BW_DEF-1:0] POSE_IDENTITY = {
    POSE_ZERO, POSE_ONE, POSE_ZERO, POSE_ZERO,
    POSE_ZERO, POSE_ZERO, POSE_ONE, POSE_ZERO,
    POSE_ZERO, POSE_ZERO, POSE_ZERO, POSE_ONE
  };
  typedef enum logic [1:0] {IDLE, MAC, FLUSH} pose_acc_state_t;
endpackage

// File: rtl/fxp_mul_round.sv
// fxp_mul_round: 2-stage signed multiply, then registered toward-zero >>> F (3-cycle latency; i_a, i_b in, o_q out)
module fxp_mul_round #(
  parameter int W = 64,
  parameter int F = 24
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_q
);
  logic signed [W-1:0] a, b;
  logic signed [2*W-1:0] p, pr;
  always_comb pr = p + (p[2*W-1] ? {{(2*W-F){1'b0}}, {F{1'b1}}} : '0);
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a <= '0;
      b <= '0;
      p <= '0;
      o_q <= '0;
    end else begin
      a <= i_a;
      b <= i_b;
      p <= a * b;
      o_q <= W'(pr >>> F);
    end
  end
endmodule

// File: rtl/pose_accumulate.sv
// pose_accumulate: composes each incremental 3x4 pose onto the running pose (acc <= inc * acc) with one shared multiplier
module pose_accumulate
  import pose_accumulate_pkg::*;
#(
  parameter int POSE_BW = POSE_BW_DEF,
  parameter int FRAC_BW = FRAC_BW_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [11:0][POSE_BW-1:0] i_pose_inc,
  input  logic                     i_clear,
  output logic [11:0][POSE_BW-1:0] o_pose_acc,
  output logic                     o_done,
  output logic                     o_busy
);
  localparam logic [POSE_BW-1:0] ONE = POSE_BW'(1) << FRAC_BW;
  localparam logic [POSE_BW-1:0] ZERO = POSE_BW'(0);
  localparam logic [11:0][POSE_BW-1:0] IDENT = {
    ZERO, ONE, ZERO, ZERO, ZERO, ZERO, ONE, ZERO, ZERO, ZERO, ZERO, ONE
  };
  localparam logic [5:0] CNT_LAST_ISSUE = 6'd35;
  localparam logic [5:0] CNT_DONE = 6'(POSE_COMPOSE_LAT - 1);
  pose_acc_state_t state, state_nxt;
  logic [5:0] cnt;
  logic [3:0] ie;
  logic [1:0] ij;
  logic [2:0] tv;
  logic [2:0][3:0] te;
  logic [2:0][1:0] tj;
  logic [3:0] ae;
  logic [1:0] aj;
  logic [11:0][POSE_BW-1:0] inc, shadow, shadow_nxt;
  logic signed [POSE_BW-1:0] mul_a, mul_b, q;
  logic signed [POSE_BW+1:0] sum, base, sum_nxt;
  logic [POSE_BW-1:0] t_in, sat;
  logic last;
  fxp_mul_round #(.W(POSE_BW), .F(FRAC_BW)) u_mul (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_a(mul_a),
    .i_b(mul_b),
    .o_q(q)
  );
  always_comb begin
    state_nxt = i_clear ? IDLE
              : state == IDLE ? (i_start ? MAC : IDLE)
              : state == MAC ? (cnt == CNT_LAST_ISSUE ? FLUSH : MAC)
              : (cnt == CNT_DONE ? IDLE : FLUSH);
    o_busy = state != IDLE;
    o_done = state == FLUSH && cnt == CNT_DONE;
    mul_a = $signed(inc[{ie[3:2], ij}]);
    mul_b = $signed(o_pose_acc[{ij, ie[1:0]}]);
    ae = te[2];
    aj = tj[2];
    t_in = inc[{ae[3:2], 2'd3}];
    base = aj != 2'd0 ? sum : ae[1:0] == 2'd3 ? {{2{t_in[POSE_BW-1]}}, t_in} : '0;
    sum_nxt = base + {{2{q[POSE_BW-1]}}, q};
    sat = (sum_nxt[POSE_BW+1:POSE_BW-1] == 3'b000 || sum_nxt[POSE_BW+1:POSE_BW-1] == 3'b111)
        ? sum_nxt[POSE_BW-1:0]
        : {sum_nxt[POSE_BW+1], {(POSE_BW-1){~sum_nxt[POSE_BW+1]}}};
    shadow_nxt = shadow;
    if (tv[2] && aj == 2'd2) shadow_nxt[ae] = sat;
    last = tv[2] && aj == 2'd2 && ae == 4'd11;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      ie <= '0;
      ij <= '0;
      tv <= '0;
      te <= '0;
      tj <= '0;
      inc <= '0;
      shadow <= '0;
      sum <= '0;
      o_pose_acc <= IDENT;
    end else begin
      state <= state_nxt;
      cnt <= state == IDLE ? 6'd0 : cnt + 6'd1;
      ij <= state != MAC || ij == 2'd2 ? 2'd0 : ij + 2'd1;
      ie <= state != MAC ? 4'd0 : ij == 2'd2 ? ie + 4'd1 : ie;
      tv <= i_clear ? 3'b000 : {tv[1:0], state == MAC};
      te <= {te[1:0], ie};
      tj <= {tj[1:0], ij};
      if (state == IDLE && i_start) inc <= i_pose_inc;
      if (tv[2]) sum <= sum_nxt;
      shadow <= shadow_nxt;
      o_pose_acc <= i_clear ? IDENT : last ? shadow_nxt : o_pose_acc;
    end
  end
endmodule

// File: tb/tb_pose_accumulate.sv
// tb_pose_accumulate: scoreboard bench for pose_accumulate with directed compositions and control corner cases
module tb_pose_accumulate;
  import pose_accumulate_pkg::*;
  typedef logic [11:0][63:0] pose_t;
  typedef struct {pose_t p; int t; string nm;} exp_t;
  localparam logic [63:0] ONE = 64'd16777216;
  localparam logic [63:0] P62 = 64'h4000_0000_0000_0000;
  localparam logic [63:0] N62 = 64'hC000_0000_0000_0000;
  logic clk = 0, rst = 1, start = 0, clr = 0;
  pose_t inc = '0, acc;
  logic done, busy;
  int cyc = 0, n_tests = 0, n_fail = 0, b = 0;
  exp_t exp_q[$];
  pose_t ident, tr, tr2, rz, rz2, rz3, m1, half, zr, col, sinc, sx;
  pose_accumulate dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .i_pose_inc(inc),
    .i_clear(clr),
    .o_pose_acc(acc),
    .o_done(done),
    .o_busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_v(input string nm, input longint act, input longint want);
    n_tests++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", nm, act, want);
    end
  endtask
  task automatic chk_p(input string nm, input pose_t act, input pose_t want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      for (int i = 0; i < 12; i++)
        if (act[i] !== want[i]) begin
          $display("FAIL %s entry %0d got %0d want %0d", nm, i, $signed(act[i]), $signed(want[i]));
          break;
        end
    end
  endtask
  always @(negedge clk) begin
    exp_t x;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done at cycle %0d got done=1 want 0", cyc);
      end else begin
        x = exp_q.pop_front();
        chk_v({x.nm, "_latency"}, longint'(cyc - x.t), 40);
        chk_p(x.nm, acc, x.p);
      end
    end
  end
  task automatic do_start(input pose_t v, input bit push, input pose_t e, input string nm);
    exp_t x;
    inc = v;
    start = 1;
    if (push) begin
      x.p = e;
      x.t = cyc;
      x.nm = nm;
      exp_q.push_back(x);
    end
    tick();
    start = 0;
    inc = '1;
  endtask
  task automatic wait_done(output int busy_n);
    bit seen;
    seen = 0;
    busy_n = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) seen = 1;
    end
    chk_v("done_seen", longint'(seen), 1);
    tick();
  endtask
  task automatic pulse_clear();
    clr = 1;
    tick();
    clr = 0;
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1, "timeout");
  end
  initial begin
    ident = '0;
    ident[R00] = ONE;
    ident[R11] = ONE;
    ident[R22] = ONE;
    tr = ident;
    tr[T0] = ONE;
    tr[T2] = -64'sd33554432;
    tr2 = ident;
    tr2[T0] = 64'd33554432;
    tr2[T2] = -64'sd67108864;
    rz = ident;
    rz[R00] = '0;
    rz[R01] = -ONE;
    rz[R10] = ONE;
    rz[R11] = '0;
    rz2 = ident;
    rz2[R00] = -ONE;
    rz2[R11] = -ONE;
    rz3 = rz;
    rz3[R01] = ONE;
    rz3[R10] = -ONE;
    m1 = ident;
    m1[R00] = '1;
    half = ident;
    half[R00] = 64'd8388608;
    zr = ident;
    zr[R00] = '0;
    col = ident;
    col[R10] = ONE;
    col[R20] = ONE;
    sinc = ident;
    sinc[R00] = P62;
    sinc[R01] = P62;
    sinc[R02] = P62;
    sinc[R10] = N62;
    sinc[R11] = N62;
    sinc[R12] = N62;
    sx = col;
    sx[R00] = 64'h7FFF_FFFF_FFFF_FFFF;
    sx[R01] = P62;
    sx[R02] = P62;
    sx[R10] = 64'h8000_0000_0000_0000;
    sx[R11] = N62;
    sx[R12] = N62;
    repeat (3) tick();
    rst = 0;
    repeat (5) tick();
    chk_p("reset_pose", acc, ident);
    chk_v("reset_done", longint'(done), 0);
    chk_v("reset_busy", longint'(busy), 0);
    do_start(ident, 1, ident, "ident_inc");
    wait_done(b);
    chk_v("busy_cycles", b, 40);
    do_start(tr, 1, tr, "trans1");
    wait_done(b);
    do_start(tr, 1, tr2, "trans2");
    wait_done(b);
    pulse_clear();
    chk_p("idle_clear_pose", acc, ident);
    chk_v("idle_clear_busy", longint'(busy), 0);
    do_start(rz, 1, rz, "rot1");
    wait_done(b);
    do_start(rz, 1, rz2, "rot2");
    wait_done(b);
    do_start(rz, 1, rz3, "rot3");
    wait_done(b);
    do_start(rz, 1, ident, "rot4");
    wait_done(b);
    do_start(m1, 1, m1, "minus_one");
    wait_done(b);
    do_start(half, 1, zr, "round_zero");
    wait_done(b);
    pulse_clear();
    do_start(col, 1, col, "col_ones");
    wait_done(b);
    do_start(sinc, 1, sx, "saturate");
    wait_done(b);
    pulse_clear();
    do_start(tr, 1, tr, "busy_start");
    repeat (9) tick();
    inc = rz;
    start = 1;
    tick();
    start = 0;
    wait_done(b);
    chk_v("busy_after_ignored_start", b, 30);
    repeat (45) tick();
    chk_p("ignored_start_pose", acc, tr);
    do_start(tr, 0, tr, "aborted");
    repeat (19) tick();
    pulse_clear();
    chk_v("abort_busy", longint'(busy), 0);
    chk_p("abort_pose", acc, ident);
    repeat (45) tick();
    chk_p("abort_pose_late", acc, ident);
    do_start(tr, 1, tr, "pre_clear_start");
    wait_done(b);
    inc = rz;
    start = 1;
    clr = 1;
    tick();
    start = 0;
    clr = 0;
    chk_v("clear_start_busy", longint'(busy), 0);
    chk_p("clear_start_pose", acc, ident);
    repeat (45) tick();
    chk_v("clear_start_busy_late", longint'(busy), 0);
    chk_p("clear_start_pose_late", acc, ident);
    chk_v("pending_expected", longint'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
